// File: rtl/spi_pkg.sv
// Shared types for the SPI transmit arbiter.
// Round-robin pick helper scans last+1, last+2, ... with wrap.
package spi_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    START,
    ACTIVE,
    DONE,
    FAULT
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         last,
    input int                 n
  );
    rr_pick_t p;
    int       j;
    p = '0;
    // Descending offset so the nearest set request wins.
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        j = (int'(last) + k) % n;
        if (req[j]) begin
          p.valid = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin winner select.
// Returns index and one-hot of the next requester after last.
module spi_rr_picker
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      idx,
  output logic [NUM_REQ-1:0] onehot
);

  rr_pick_t p;

  always_comb begin
    p      = rr_pick(MAX_REQ'(req), 3'(last), NUM_REQ);
    valid  = p.valid;
    idx    = IW'(p.idx);
    onehot = NUM_REQ'(1) << p.idx;
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin sequencer sharing one spi_go transmitter.
// Launches GO, tracks SS_N, acks the winner or flags a timeout.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_LENGTH   = 8,
  parameter int START_TIMEOUT = 4,
  parameter int XFER_TIMEOUT  = 2*DATA_LENGTH+8
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] DATA,
  output logic [NUM_REQ-1:0]             ACK,
  output logic [NUM_REQ-1:0]             SEL,
  output logic [$clog2(NUM_REQ)-1:0]     GNT_ID,
  output logic                           BUSY,
  output logic                           ERR,
  output logic                           SPI_GO,
  output logic [DATA_LENGTH-1:0]         SPI_DATA,
  input  logic                           SPI_SS_N
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int TMAX = (START_TIMEOUT > XFER_TIMEOUT) ?
                        START_TIMEOUT : XFER_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);

  arb_state_t           state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic [IW-1:0]        last_grant;
  logic                 pick_v;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (REQ),
    .last   (last_grant),
    .valid  (pick_v),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // Saturating watchdog count.
  assign cnt_inc = (cnt == CW'(TMAX)) ? cnt : cnt + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= IW'(NUM_REQ-1);
      ACK        <= '0;
      SEL        <= '0;
      GNT_ID     <= '0;
      BUSY       <= 1'b0;
      ERR        <= 1'b0;
      SPI_GO     <= 1'b0;
      SPI_DATA   <= '0;
    end else begin
      SPI_GO <= 1'b0;
      ACK    <= '0;
      ERR    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_v) begin
            state    <= LAUNCH;
            SPI_DATA <= DATA[pick_idx*DATA_LENGTH +: DATA_LENGTH];
            SEL      <= pick_oh;
            GNT_ID   <= pick_idx;
            SPI_GO   <= 1'b1;
            BUSY     <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= START;
          cnt   <= '0;
        end
        START: begin
          if (!SPI_SS_N) begin
            state <= ACTIVE;
            cnt   <= '0;
          end else if (cnt == CW'(START_TIMEOUT-1)) begin
            state <= FAULT;
            ERR   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ACTIVE: begin
          if (SPI_SS_N) begin
            state <= DONE;
            ACK   <= SEL;
          end else if (cnt == CW'(XFER_TIMEOUT-1)) begin
            state <= FAULT;
            ERR   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE, FAULT: begin
          last_grant <= GNT_ID;
          SEL        <= '0;
          BUSY       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          last_grant <= IW'(NUM_REQ-1);
          SEL        <= '0;
          GNT_ID     <= '0;
          BUSY       <= 1'b0;
          SPI_DATA   <= '0;
        end
      endcase
    end
  end

endmodule
